uart_rx_fifo: RTL and testbench

- UART receiver peripheral for the 9x8 processor core: deserializes 8N1 asynchronous serial input and buffers received bytes in a small FIFO.
- The processor reads bytes through a read strobe.
- It is the receive-side counterpart of the core's serial transmit peripheral.
- It sits on the core's I/O port bus and is instantiated alongside the core in the system top level and in test benches.

---
 rtl/uart_rx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO and sticky frame/overflow status.
// The serial line is double-synchronized; every bit is sampled mid-bit by a reloading down-counter.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int G_CLK_PER_BAUD = 100,
  parameter int G_DEPTH_LOG2   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_rd,
  output logic [7:0] o_data,
  output logic       o_empty,
  input  logic       i_clr_status,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int CW    = $clog2(G_CLK_PER_BAUD);
  localparam int A     = G_DEPTH_LOG2;
  localparam int DEPTH = 1 << A;
  localparam logic [CW-1:0] FULL_CNT = CW'(G_CLK_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(G_CLK_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [A:0]    PTR_ONE  = (A + 1)'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_e;

  state_e        state_q;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;

  logic          cnt_done, wr_req, fe_set;

  logic [7:0]    mem_q [DEPTH];
  logic [A:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    data_q, data_d;
  logic          empty_q, empty_d, overflow_q, overflow_d;
  logic          full, wr_en, rd_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign cnt_done = (cnt_q == '0);
  assign wr_req   = (state_q == ST_STOP) && cnt_done && rx_sync_q;
  assign fe_set   = (state_q == ST_STOP) && cnt_done && !rx_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      // A set event in the same cycle as a clear must leave the flag set.
      if (fe_set)            frame_err_q <= 1'b1;
      else if (i_clr_status) frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!rx_sync_q) begin
            cnt_q   <= HALF_CNT;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_done) begin
            if (!rx_sync_q) begin
              cnt_q     <= FULL_CNT;
              bit_idx_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_done) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= FULL_CNT;
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_done) state_q <= rx_sync_q ? ST_IDLE : ST_BREAK;
          else          cnt_q   <= cnt_q - CNT_ONE;
        end
        ST_BREAK: begin
          if (rx_sync_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign full = (wr_ptr_q[A] != rd_ptr_q[A]) && (wr_ptr_q[A-1:0] == rd_ptr_q[A-1:0]);

  always_comb begin
    wr_en    = wr_req && !full;
    rd_en    = i_rd && !empty_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    empty_d  = (rd_ptr_d == wr_ptr_d);
    // Bypass the incoming byte when it lands in the slot the head will point at.
    if (wr_en && (wr_ptr_q[A-1:0] == rd_ptr_d[A-1:0])) data_d = shift_q;
    else                                                data_d = mem_q[rd_ptr_d[A-1:0]];
    if (wr_req && full)    overflow_d = 1'b1;
    else if (i_clr_status) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[A-1:0]] <= shift_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_q     <= '0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_data      = data_q;
  assign o_empty     = empty_q;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 16 clocks per bit, 4-entry FIFO.
// Frames are driven one bit every 16 cycles; stop-bit sample edge is 11 edges into the stop bit.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_rd = 1'b0;
  logic       i_clr_status = 1'b0;
  logic [7:0] o_data;
  logic       o_empty, o_frame_err, o_overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.G_CLK_PER_BAUD(16), .G_DEPTH_LOG2(2)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .i_rd(i_rd),
    .o_data(o_data), .o_empty(o_empty), .i_clr_status(i_clr_status),
    .o_frame_err(o_frame_err), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Drives one frame starting just after a clock edge; es = {empty before, empty after} the stop sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic rd_at_stop,
                            input logic clr_at_stop, output logic [1:0] es);
    i_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (16) @(posedge clk);
      #1;
    end
    i_rx = stop_val;
    repeat (10) @(posedge clk);
    #1;
    es[1] = o_empty;
    i_rd = rd_at_stop;
    i_clr_status = clr_at_stop;
    @(posedge clk);
    #1;
    es[0] = o_empty;
    i_rd = 1'b0;
    i_clr_status = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    i_rd = 1'b1;
    @(posedge clk);
    #1;
    i_rd = 1'b0;
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", o_frame_err); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
    i_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    logic [1:0] es;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, es);
    checks++; if (es !== 2'b10) begin errors++; $display("FAIL single_empty_timing: got %b expected 10", es); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", o_data); end
    checks++; if ({o_frame_err, o_overflow} !== 2'b00) begin errors++; $display("FAIL single_status: got %b expected 00", {o_frame_err, o_overflow}); end
    pulse_rd();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL single_read_empty: got %b expected 1", o_empty); end
    $display("test_single_byte rx=%h", 8'hA5);
  endtask

  task automatic test_glitch();
    logic [1:0] es;
    i_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b expected 1", o_empty); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b expected 0", o_frame_err); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, es);
    checks++; if (es !== 2'b10) begin errors++; $display("FAIL glitch_next_empty: got %b expected 10", es); end
    checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data: got %h expected 3c", o_data); end
    pulse_rd();
    $display("test_glitch then rx=%h", 8'h3C);
  endtask

  task automatic test_frame_error();
    logic [1:0] es;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, es);
    repeat (24) @(posedge clk);
    #1;
    i_rx = 1'b1;
    checks++; if (es !== 2'b11) begin errors++; $display("FAIL ferr_no_write: got %b expected 11", es); end
    checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", o_frame_err); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ferr_empty: got %b expected 1", o_empty); end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, es);
    checks++; if (o_data !== 8'h81 || es !== 2'b10) begin errors++; $display("FAIL ferr_next: got data %h es %b expected data 81 es 10", o_data, es); end
    checks++; if (o_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", o_frame_err); end
    pulse_rd();
    i_clr_status = 1'b1;
    @(posedge clk);
    #1;
    i_clr_status = 1'b0;
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", o_frame_err); end
    $display("test_frame_error then rx=%h", 8'h81);
  endtask

  task automatic test_overflow();
    logic [1:0] es;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, (b == 5), es);
      if (b == 4) begin
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", o_overflow); end
      end
    end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", o_overflow); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (o_empty !== 1'b0 || o_data !== 8'(k)) begin errors++; $display("FAIL ovf_read%0d: got empty %b data %h expected empty 0 data %h", k, o_empty, o_data, 8'(k)); end
      pulse_rd();
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", o_empty); end
    $display("test_overflow read 01..04");
  endtask

  task automatic test_reset_midframe();
    logic [1:0] es;
    logic [7:0] f0;
    f0 = 8'hF0;
    i_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      i_rx = f0[i];
      if (i < 4) begin
        repeat (16) @(posedge clk);
        #1;
      end
    end
    repeat (8) @(posedge clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_empty, o_data, o_frame_err, o_overflow} !== {1'b1, 8'h00, 2'b00})
      begin errors++; $display("FAIL midreset_values: got %b %h %b %b expected 1 00 0 0", o_empty, o_data, o_frame_err, o_overflow); end
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    i_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL midreset_no_partial: got %b expected 1", o_empty); end
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, es);
    checks++; if (o_data !== 8'h0F || es !== 2'b10) begin errors++; $display("FAIL midreset_next: got data %h es %b expected data 0f es 10", o_data, es); end
    pulse_rd();
    $display("test_reset_midframe then rx=%h", 8'h0F);
  endtask

  task automatic test_back_to_back();
    logic [1:0] es;
    send_frame(8'h10, 1'b1, 1'b1, 1'b0, es);
    checks++; if (es !== 2'b10 || o_data !== 8'h10) begin errors++; $display("FAIL b2b_first: got es %b data %h expected es 10 data 10", es, o_data); end
    send_frame(8'h20, 1'b1, 1'b1, 1'b0, es);
    checks++; if (es !== 2'b00 || o_data !== 8'h20) begin errors++; $display("FAIL b2b_second: got es %b data %h expected es 00 data 20", es, o_data); end
    send_frame(8'h30, 1'b1, 1'b1, 1'b0, es);
    checks++; if (es !== 2'b00 || o_data !== 8'h30) begin errors++; $display("FAIL b2b_third: got es %b data %h expected es 00 data 30", es, o_data); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", o_overflow); end
    pulse_rd();
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty: got %b expected 1", o_empty); end
    $display("test_back_to_back rx=10,20,30");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
